// File: rtl/fetch_unit_if.sv
// -----------------------------------------------------------------------------
// fetch_unit_if
//   Instruction-memory read port between the fetch unit and the instruction
//   memory. The memory answers in the same cycle it accepts a request.
//
//   Signals
//     imem_req   : read request; the fetcher drives it
//     imem_addr  : 32-bit word-aligned read address; the fetcher drives it
//     imem_ready : memory accepts the request and returns data this cycle
//     imem_rdata : instruction word, valid when imem_req && imem_ready
//
//   Modports
//     master : fetch side (drives req/addr, samples ready/rdata)
//     slave  : memory side
// -----------------------------------------------------------------------------
interface fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   Instruction fetch stage with an IF/ID output register. The stage fetches
//   sequential words from instruction memory and follows downstream redirects.
//   It freezes on stall and inserts bubbles while memory is not ready.
//
//   Parameters
//     RESET_PC        : PC loaded on reset
//
//   Ports
//     clk             : single clock, rising edge
//     rst             : synchronous, active-high reset
//     stall           : hold IF/ID outputs and PC, no new fetch
//     redirect        : taken branch / jump from downstream (wins over stall)
//     redirect_target : new PC; bits [1:0] are dropped and flagged via misalign
//     imem_bus        : instruction memory read port (master side)
//     instr           : registered instruction word (NOP after reset)
//     pc_out          : PC of instr
//     pc_plus4        : pc_out + 4, used for link writes
//     instr_valid     : instr/pc_out hold a live instruction
//     misalign        : one-cycle pulse after a redirect to a non-word target
//     fetch_count     : number of instructions delivered (wraps mod 2^32)
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              redirect,
    input  logic [31:0]       redirect_target,
    fetch_unit_if.master      imem_bus,
    output logic [31:0]       instr,
    output logic [31:0]       pc_out,
    output logic [31:0]       pc_plus4,
    output logic              instr_valid,
    output logic              misalign,
    output logic [31:0]       fetch_count
);

    localparam logic [31:0] NOP_INSTR      = 32'h0000_0013;
    localparam logic [29:0] RESET_WORD     = RESET_PC[31:2];
    localparam logic [31:0] RESET_PC_PLUS4 = RESET_PC + 32'd4;

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    // The PC is kept as a word index. Its low two bits are always zero, so
    // they need no storage. Adding 1 to the word index wraps exactly like a
    // 32-bit PC + 4.
    logic [29:0] r_pc_word;
    logic [31:0] r_instr;
    logic [31:0] r_pc_out;
    logic [31:0] r_pc_plus4;
    logic        r_instr_valid;
    logic        r_misalign;
    logic [31:0] r_fetch_count;

    logic        w_req;
    logic        w_accept;
    logic        w_target_misaligned;
    logic [29:0] w_pc_word_inc;

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_RESET;
        end else begin
            r_state <= w_state_next;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next state and request generation
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_req        = 1'b0;
        case (r_state)
            ST_RESET: begin
                w_state_next = ST_FETCH;
            end
            ST_FETCH: begin
                if (stall && !redirect) begin
                    w_state_next = ST_HOLD;
                end
                w_req = !stall && !redirect;
            end
            ST_HOLD: begin
                // Leaving HOLD does not fetch in the same cycle. The first
                // new request goes out from FETCH on the following cycle.
                if (!stall || redirect) begin
                    w_state_next = ST_FETCH;
                end
            end
            default: begin
                w_state_next = ST_RESET;
            end
        endcase
        // A reset cycle never issues a request, whatever state we are in.
        if (rst) begin
            w_req = 1'b0;
        end
    end

    assign w_accept            = w_req && imem_bus.imem_ready;
    assign w_target_misaligned = (redirect_target[1:0] != 2'b00);
    assign w_pc_word_inc       = r_pc_word + 30'd1;

    // -------------------------------------------------------------------------
    // PC, IF/ID register, misalign flag and delivery counter
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc_word     <= RESET_WORD;
            r_instr       <= NOP_INSTR;
            r_pc_out      <= RESET_PC;
            r_pc_plus4    <= RESET_PC_PLUS4;
            r_instr_valid <= 1'b0;
            r_misalign    <= 1'b0;
            r_fetch_count <= 32'd0;
        end else begin
            r_misalign <= redirect && w_target_misaligned;
            if (redirect) begin
                // The low target bits are dropped here. The misalign pulse
                // reports that they were not zero.
                r_pc_word     <= redirect_target[31:2];
                r_instr_valid <= 1'b0;
            end else if (stall) begin
                // Freeze everything: PC, IF/ID contents and the counter.
                r_pc_word <= r_pc_word;
            end else if (w_accept) begin
                r_instr       <= imem_bus.imem_rdata;
                r_pc_out      <= {r_pc_word, 2'b00};
                r_pc_plus4    <= {w_pc_word_inc, 2'b00};
                r_instr_valid <= 1'b1;
                r_pc_word     <= w_pc_word_inc;
                r_fetch_count <= r_fetch_count + 32'd1;
            end else begin
                // No word arrived this cycle. The cause can be memory not
                // ready, the RESET state, or the cycle that leaves HOLD.
                // Downstream sees a bubble, and the old instr stays in place.
                r_instr_valid <= 1'b0;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign imem_bus.imem_req  = w_req;
    assign imem_bus.imem_addr = {r_pc_word, 2'b00};
    assign instr              = r_instr;
    assign pc_out             = r_pc_out;
    assign pc_plus4           = r_pc_plus4;
    assign instr_valid        = r_instr_valid;
    assign misalign           = r_misalign;
    assign fetch_count        = r_fetch_count;

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//   Directed bench for fetch_unit. A behavioural model tracks the architectural
//   outcome of every cycle: the PC, the IF/ID contents, the counter and whether
//   a request may go out. A negedge process compares every DUT output against
//   that model. Literal expectations after key steps pin the model itself.
//   The memory is combinational: rdata = addr ^ 32'hA5A5_0000.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_target;
    logic        rdy;
    logic [31:0] instr;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4;
    logic        instr_valid;
    logic        misalign;
    logic [31:0] fetch_count;

    fetch_unit_if bus ();
    assign bus.imem_ready = rdy;
    assign bus.imem_rdata = bus.imem_addr ^ 32'hA5A5_0000;

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .imem_bus        (bus),
        .instr           (instr),
        .pc_out          (pc_out),
        .pc_plus4        (pc_plus4),
        .instr_valid     (instr_valid),
        .misalign        (misalign),
        .fetch_count     (fetch_count)
    );

    int n_vec = 0;
    int n_bad = 0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual %08h required %08h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // ---------------- behavioural model ----------------
    bit          m_known     = 1'b0;  // a reset has been applied
    bit          m_after_rst = 1'b0;  // previous edge was a reset edge
    bit          m_prev_hold = 1'b0;  // previous edge froze on stall
    logic [31:0] m_pc        = 32'd0;
    logic [31:0] m_instr     = 32'd0;
    logic [31:0] m_pc_out    = 32'd0;
    bit          m_valid     = 1'b0;
    bit          m_mis       = 1'b0;
    logic [31:0] m_count     = 32'd0;

    // A request may go out only when the fetcher is running. It is not
    // running in the cycle after a reset edge or in the cycle after a stall.
    // It also needs no stall, no redirect and no reset this cycle.
    function automatic bit exp_req();
        return m_known && !rst && !m_after_rst && !m_prev_hold && !stall && !redirect;
    endfunction

    // Apply one cycle of inputs, let the edge happen, then advance the model.
    task automatic step(input bit r, input bit s, input bit rd,
                        input logic [31:0] tgt, input bit ready);
        bit acc;
        rst             = r;
        stall           = s;
        redirect        = rd;
        redirect_target = tgt;
        rdy             = ready;
        acc = exp_req() && ready;
        @(posedge clk);
        #1;
        if (r) begin
            m_known     = 1'b1;
            m_pc        = 32'd0;
            m_instr     = 32'h0000_0013;
            m_pc_out    = 32'd0;
            m_valid     = 1'b0;
            m_mis       = 1'b0;
            m_count     = 32'd0;
            m_after_rst = 1'b1;
            m_prev_hold = 1'b0;
        end else if (m_known) begin
            m_prev_hold = !m_after_rst && s && !rd;
            m_after_rst = 1'b0;
            if (rd) begin
                m_pc    = tgt - (tgt % 4);
                m_valid = 1'b0;
                m_mis   = (tgt % 4) != 0;
            end else begin
                m_mis = 1'b0;
                if (!s) begin
                    if (acc) begin
                        m_instr  = m_pc ^ 32'hA5A5_0000;
                        m_pc_out = m_pc;
                        m_valid  = 1'b1;
                        m_count  = m_count + 1;
                        m_pc     = m_pc + 4;
                    end else begin
                        m_valid = 1'b0;
                    end
                end
            end
        end
    endtask

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (m_known) begin
            check("imem_req",    {31'd0, bus.imem_req}, {31'd0, exp_req()});
            check("imem_addr",   bus.imem_addr,         m_pc);
            check("instr",       instr,                 m_instr);
            check("pc_out",      pc_out,                m_pc_out);
            check("pc_plus4",    pc_plus4,              m_pc_out + 32'd4);
            check("instr_valid", {31'd0, instr_valid},  {31'd0, m_valid});
            check("misalign",    {31'd0, misalign},     {31'd0, m_mis});
            check("fetch_count", fetch_count,           m_count);
        end
    end

    // ---------------- directed stimulus ----------------
    initial begin
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_target = 32'd0; rdy = 1'b0;

        // Reset
        step(1, 0, 0, 32'h0, 1);
        step(1, 0, 0, 32'h0, 1);
        check("rst_instr",    instr,       32'h0000_0013);
        check("rst_pc_out",   pc_out,      32'h0000_0000);
        check("rst_pc_plus4", pc_plus4,    32'h0000_0004);
        check("rst_valid",    {31'd0, instr_valid}, 32'd0);
        check("rst_count",    fetch_count, 32'd0);
        check("rst_req",      {31'd0, bus.imem_req}, 32'd0);

        // RESET state cycle, then the first request from RESET_PC
        step(0, 0, 0, 32'h0, 1);
        check("first_req",  {31'd0, bus.imem_req}, 32'd1);
        check("first_addr", bus.imem_addr, 32'h0000_0000);

        // Sequential fetches 0, 4, 8
        for (int i = 0; i < 3; i++) step(0, 0, 0, 32'h0, 1);
        check("seq_instr",  instr,         32'hA5A5_0008);
        check("seq_pc_out", pc_out,        32'h0000_0008);
        check("seq_count",  fetch_count,   32'd3);
        check("seq_addr",   bus.imem_addr, 32'h0000_000C);

        // Stall for two cycles after the fetch at PC 8
        step(0, 1, 0, 32'h0, 1);
        step(0, 1, 0, 32'h0, 1);
        check("stall_pc_out", pc_out,      32'h0000_0008);
        check("stall_instr",  instr,       32'hA5A5_0008);
        check("stall_req",    {31'd0, bus.imem_req}, 32'd0);
        check("stall_count",  fetch_count, 32'd3);
        step(0, 0, 0, 32'h0, 1);
        check("resume_addr", bus.imem_addr, 32'h0000_000C);
        check("resume_req",  {31'd0, bus.imem_req}, 32'd1);

        // Fetch C and 10, then memory is not ready for 3 cycles
        step(0, 0, 0, 32'h0, 1);
        step(0, 0, 0, 32'h0, 1);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 32'h0, 0);
        check("notrdy_addr",  bus.imem_addr, 32'h0000_0014);
        check("notrdy_valid", {31'd0, instr_valid}, 32'd0);
        check("notrdy_count", fetch_count, 32'd5);
        step(0, 0, 0, 32'h0, 1);
        check("after_wait_pc", pc_out, 32'h0000_0014);
        check("after_wait_ct", fetch_count, 32'd6);

        // Redirect to 0x40 together with stall: the redirect wins
        step(0, 1, 1, 32'h0000_0040, 1);
        check("redir_addr",  bus.imem_addr, 32'h0000_0040);
        check("redir_valid", {31'd0, instr_valid}, 32'd0);
        check("redir_mis",   {31'd0, misalign}, 32'd0);
        check("redir_count", fetch_count, 32'd6);
        step(0, 0, 0, 32'h0, 1);
        check("redir_fetch", pc_out, 32'h0000_0040);

        // Redirect while already in HOLD
        step(0, 1, 0, 32'h0, 1);
        step(0, 1, 1, 32'h0000_0080, 1);
        step(0, 0, 0, 32'h0, 1);
        check("hold_redir_pc", pc_out,      32'h0000_0080);
        check("hold_redir_ct", fetch_count, 32'd8);

        // Misaligned redirect target
        step(0, 0, 1, 32'h0000_0043, 1);
        check("mis_pulse", {31'd0, misalign}, 32'd1);
        check("mis_addr",  bus.imem_addr, 32'h0000_0040);
        step(0, 0, 0, 32'h0, 1);
        check("mis_clear", {31'd0, misalign}, 32'd0);

        // PC wrap from FFFF_FFFC to 0
        step(0, 0, 1, 32'hFFFF_FFFC, 1);
        step(0, 0, 0, 32'h0, 1);
        check("wrap_pc_out", pc_out,        32'hFFFF_FFFC);
        check("wrap_plus4",  pc_plus4,      32'h0000_0000);
        check("wrap_instr",  instr,         32'h5A5A_FFFC);
        check("wrap_addr",   bus.imem_addr, 32'h0000_0000);
        step(0, 0, 0, 32'h0, 1);
        check("wrap_next", instr, 32'hA5A5_0000);

        // Reset arriving while a fetch at 0x10 is offered
        step(0, 0, 1, 32'h0000_0010, 1);
        step(1, 0, 0, 32'h0, 1);
        check("mid_rst_count", fetch_count, 32'd0);
        check("mid_rst_instr", instr,       32'h0000_0013);
        check("mid_rst_pc",    pc_out,      32'h0000_0000);
        step(0, 0, 0, 32'h0, 1);
        check("mid_rst_addr", bus.imem_addr, 32'h0000_0000);
        check("mid_rst_req",  {31'd0, bus.imem_req}, 32'd1);
        step(0, 0, 0, 32'h0, 1);
        check("mid_rst_fetch", fetch_count, 32'd1);

        step(0, 0, 0, 32'h0, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, giving the PC loaded on reset.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port stall, input, 1 bit: hold the IF/ID outputs and the PC; no new fetch.
REQ-005 The block SHALL have port redirect, input, 1 bit: taken branch or jump (PCSrc) from downstream.
REQ-006 The block SHALL have port redirect_target, input, 32 bits: branch target, PC + ImmOp, computed downstream.
REQ-007 The block SHALL have port imem_req, output, 1 bit: instruction memory read request.
REQ-008 The block SHALL have port imem_addr, output, 32 bits: word-aligned read address.
REQ-009 The block SHALL have port imem_ready, input, 1 bit: memory accepts and returns data in the same cycle.
REQ-010 The block SHALL have port imem_rdata, input, 32 bits: instruction word, valid when imem_req && imem_ready.
REQ-011 The block SHALL have port instr, output, 32 bits: registered instruction fed to the immediate sign-extender and decoder.
REQ-012 The block SHALL have port pc_out, output, 32 bits: PC of instr.
REQ-013 The block SHALL have port pc_plus4, output, 32 bits: pc_out + 4, used for link writes.
REQ-014 The block SHALL have port instr_valid, output, 1 bit: instr/pc_out hold a live instruction.
REQ-015 The block SHALL have port misalign, output, 1 bit: one-cycle pulse when redirect_target[1:0] != 0.
REQ-016 The block SHALL have port fetch_count, output, 32 bits: count of instructions delivered.

Function
REQ-017 The block SHALL implement the FSM states RESET, FETCH and HOLD, with RESET entered only via rst.
- RESET -> FETCH on the next cycle.
- FETCH -> HOLD when stall=1 and redirect=0.
- HOLD -> FETCH when stall=0 or redirect=1.
REQ-018 The block SHALL drive imem_req=1 only in FETCH with stall=0 and redirect=0, and 0 otherwise.
REQ-019 The block SHALL drive imem_addr from the internal PC register, with bits [1:0] always 0.
REQ-020 On an accepted fetch (imem_req && imem_ready), the block SHALL, next cycle:
- set instr <= imem_rdata;
- set pc_out <= PC and pc_plus4 <= PC+4;
- set instr_valid <= 1;
- set PC <= PC+4;
- increment fetch_count by 1.
REQ-021 In FETCH with imem_ready=0, the block SHALL keep PC unchanged, set instr_valid <= 0 (bubble) and leave instr unchanged.
REQ-022 While stall=1 and redirect=0, the block SHALL hold PC, instr, pc_out, pc_plus4, instr_valid and fetch_count unchanged.
REQ-023 On redirect=1, the block SHALL, next cycle:
- set PC <= {redirect_target[31:2],2'b00};
- set instr_valid <= 0;
- leave fetch_count unchanged;
- discard any memory response in that cycle (imem_req is already 0 per REQ-018).
REQ-024 The block SHALL give redirect priority over stall when both are asserted in the same cycle.
REQ-025 The block SHALL assert misalign for exactly the cycle after a redirect with redirect_target[1:0] != 0, and deassert it otherwise.
REQ-026 The block SHALL perform all PC and fetch_count arithmetic modulo 2^32: PC 32'hFFFF_FFFC + 4 wraps to 0, and fetch_count wraps to 0 silently.
REQ-027 The block SHALL have a fetch-to-instr latency of 1 cycle (accepted at edge N, visible after edge N).

Reset
REQ-028 When rst=1 at a clock edge, the block SHALL apply reset regardless of stall, redirect or in-flight fetch, dropping any accepted response in that cycle:
- state=RESET, PC=RESET_PC;
- instr=32'h0000_0013 (NOP);
- pc_out=RESET_PC, pc_plus4=RESET_PC+4;
- instr_valid=0, misalign=0, fetch_count=0;
- imem_req=0 during the reset cycle and the RESET state.
REQ-029 The block SHALL issue its first request, with imem_addr=RESET_PC, two cycles after rst is released.

Verification
REQ-030 The bench SHALL cover these directed scenarios:
- Reset then imem_ready=1 constant, rdata=addr^32'hA5A5_0000 -> addresses 0,4,8,..., instr matches each address 1 cycle later, fetch_count=N after N fetches.
- imem_ready low 3 cycles mid-stream -> imem_addr held, instr_valid=0 for 3 cycles, no skipped or duplicated PC.
- stall 2 cycles after fetch at PC=8 -> instr/pc_out frozen at PC=8, imem_req=0, resume fetch at 12.
- redirect with target 32'h0000_0040 while stall=1 -> next imem_addr=0x40, instr_valid=0 one cycle, misalign=0.
- redirect target 32'h0000_0043 -> misalign pulses 1 cycle, imem_addr=0x40.
- rst asserted during accepted fetch at PC=0x10 -> outputs reach the REQ-028 values, next request at RESET_PC; separately, PC at 0xFFFF_FFFC wraps to 0.
